// File: rtl/serial_shift_ctrl_if.sv
// Request/result bundle for the multi-cycle shift controller.
//
// Handshake: the controller samples start_i only while it is not shifting
// (busy_o low). A start sampled at a rising edge captures op_i, shamt_i and
// data_i on that edge; those inputs are don't-care at every other edge.
// done_o is a registered one-cycle pulse marking data_o as the valid result,
// and data_o then holds until the next accepted start. A start seen while
// busy_o is high is dropped, not queued.
interface serial_shift_ctrl_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start_i;
    logic [1:0]         op_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [WIDTH-1:0]   data_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH-1:0]   data_o;

    // Requester side (ALU sequencer or bench)
    modport master (
        output start_i, op_i, shamt_i, data_i,
        input  busy_o, done_o, data_o
    );

    // Shift controller side
    modport slave (
        input  start_i, op_i, shamt_i, data_i,
        output busy_o, done_o, data_o
    );
endinterface

// File: rtl/serial_shift_ctrl.sv
// Multi-cycle shift unit controller: reuses a single 1-bit shift stage for
// shamt cycles to perform SLL/SRL/SRA/ROL without a barrel shifter.
module serial_shift_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    serial_shift_ctrl_if.slave   bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    state_t             state, state_next;
    logic [WIDTH-1:0]   data_r, data_next;
    logic [SHAMT_W-1:0] cnt, cnt_next;
    logic [1:0]         op_r, op_next;
    logic               busy_r, done_r;

    // One bit of shift/rotate; the whole datapath is this single stage.
    function automatic logic [WIDTH-1:0] step(input logic [1:0] op,
                                              input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Next-state and datapath: accept in IDLE/DONE, iterate in SHIFT.
    always_comb begin
        state_next = state;
        data_next  = data_r;
        cnt_next   = cnt;
        op_next    = op_r;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    data_next  = bus.data_i;
                    op_next    = bus.op_i;
                    cnt_next   = bus.shamt_i;
                    // A zero shift completes immediately with the operand.
                    state_next = (bus.shamt_i == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_next = step(op_r, data_r);
                cnt_next  = cnt - 1'b1;
                if (cnt == SHAMT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, working register and registered status flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= ST_IDLE;
            data_r <= '0;
            cnt    <= '0;
            op_r   <= OP_SLL;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            data_r <= data_next;
            cnt    <= cnt_next;
            op_r   <= op_next;
            busy_r <= (state_next == ST_SHIFT);
            done_r <= (state_next == ST_DONE);
        end
    end

    assign bus.data_o = data_r;
    assign bus.busy_o = busy_r;
    assign bus.done_o = done_r;
    assign state_dbg  = state;

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Self-checking bench for serial_shift_ctrl: expected results are queued when
// a start is driven and compared when done_o appears.
module tb_serial_shift_ctrl;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    // ---------------- clock / reset ----------------
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [1:0] state_dbg;

    always #5 clk_i = ~clk_i;

    serial_shift_ctrl_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    serial_shift_ctrl #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [WIDTH-1:0] exp_q[$];
    int               exp_cyc_q[$];
    int               exp_busy_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               busy_cnt = 0;
    logic [WIDTH-1:0] last_result = '0;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference result computed with whole-word operators.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op,
                                                   input logic [SHAMT_W-1:0] sh,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        case (op)
            SLL:     r = d << sh;
            SRL:     r = d >> sh;
            SRA:     r = $signed(d) >>> sh;
            default: r = (sh == 0) ? d : ((d << sh) | (d >> (WIDTH - int'(sh))));
        endcase
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        if (!rst_i) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_done", {31'b0, bus.done_o}, '0);
                end else begin
                    check_eq("result", bus.data_o, exp_q.pop_front());
                    check_eq("done_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                    check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_busy_q.pop_front()));
                    busy_cnt    = 0;
                    last_result = bus.data_o;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic start, input logic [1:0] op,
                         input logic [SHAMT_W-1:0] sh, input logic [WIDTH-1:0] d);
        bus.start_i = start;
        bus.op_i    = op;
        bus.shamt_i = sh;
        bus.data_i  = d;
    endtask

    // Accept edge is the next posedge, so done is expected at cyc+1+sh.
    task automatic push_exp(input logic [1:0] op, input logic [SHAMT_W-1:0] sh,
                            input logic [WIDTH-1:0] d, input int accept_cyc);
        exp_q.push_back(ref_shift(op, sh, d));
        exp_cyc_q.push_back(accept_cyc + int'(sh));
        exp_busy_q.push_back(int'(sh));
    endtask

    task automatic start_op(input logic [1:0] op, input logic [SHAMT_W-1:0] sh,
                            input logic [WIDTH-1:0] d);
        @(negedge clk_i);
        drive(1'b1, op, sh, d);
        push_exp(op, sh, d, cyc + 1);
        @(negedge clk_i);
        bus.start_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_i);
        check_eq(tag, 32'(exp_q.size()), '0);
    endtask

    task automatic check_hold();
        repeat (3) @(negedge clk_i);
        check_eq("hold_data", bus.data_o, last_result);
        check_eq("hold_done", {31'b0, bus.done_o}, '0);
        check_eq("hold_busy", {31'b0, bus.busy_o}, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b0, SLL, '0, '0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_data", bus.data_o, '0);
        check_eq("rst_busy", {31'b0, bus.busy_o}, '0);
        check_eq("rst_done", {31'b0, bus.done_o}, '0);
        check_eq("rst_state", {30'b0, state_dbg}, '0);
        rst_i = 1'b1;

        // Directed operations
        start_op(SLL, 5'd2, 32'h0000_0003);   drain("drain_sll2");
        check_eq("sll2_value", last_result, 32'h0000_000C);
        start_op(SRA, 5'd31, 32'h8000_0000);  drain("drain_sra31");
        check_eq("sra31_value", last_result, 32'hFFFF_FFFF);
        start_op(SRL, 5'd31, 32'h8000_0000);  drain("drain_srl31");
        check_eq("srl31_value", last_result, 32'h0000_0001);
        start_op(ROL, 5'd1, 32'h8000_0001);   drain("drain_rol1");
        check_eq("rol1_value", last_result, 32'h0000_0003);
        check_hold();

        // Zero shift on every op: done the cycle after accept, no busy
        for (int op = 0; op < 4; op++) begin
            start_op(2'(op), 5'd0, 32'hA5C3_0F81);
            drain("drain_zero");
        end

        // Start pulsed mid-shift must be ignored
        start_op(SLL, 5'd4, 32'h0000_0001);
        @(negedge clk_i);
        drive(1'b1, SRL, 5'd7, 32'hFFFF_FFFF);
        @(negedge clk_i);
        bus.start_i = 1'b0;
        drain("drain_ignore");
        check_eq("ignore_value", last_result, 32'h0000_0010);
        check_hold();

        // Reset during the third cycle of a 10-step op aborts it
        start_op(SLL, 5'd10, 32'h0000_0001);
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check_eq("abort_data", bus.data_o, '0);
        check_eq("abort_busy", {31'b0, bus.busy_o}, '0);
        check_eq("abort_done", {31'b0, bus.done_o}, '0);
        exp_q.delete();
        exp_cyc_q.delete();
        exp_busy_q.delete();
        last_result = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (15) @(negedge clk_i);
        check_hold();
        start_op(SRA, 5'd3, 32'hF000_0000);  drain("drain_post_rst");

        // Start held high across done: SLL 1 by 1, then SRL by 0 on 0x2
        @(negedge clk_i);
        drive(1'b1, SLL, 5'd1, 32'h0000_0001);
        push_exp(SLL, 5'd1, 32'h0000_0001, cyc + 1);
        @(negedge clk_i);
        drive(1'b1, SRL, 5'd0, 32'h0000_0002);
        push_exp(SRL, 5'd0, 32'h0000_0002, cyc + 2);
        @(negedge clk_i);
        @(negedge clk_i);
        bus.start_i = 1'b0;
        drain("drain_b2b");
        check_hold();

        // Random operations
        for (int i = 0; i < 12; i++) begin
            start_op(2'($urandom_range(0, 3)), 5'($urandom_range(0, WIDTH - 1)),
                     32'($urandom));
            drain("drain_rand");
        end

        check_eq("queue_empty", 32'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
